// File: rtl/usb_io_pkg.sv
// Shared definitions for the USB byte I/O peripheral: register offsets,
// STATUS/CTRL bit positions and the byte type carried on both sides.
package usb_io_pkg;

    typedef logic [7:0] byte_t;

    // Register offsets within the 4-byte window
    localparam logic [1:0] USB_IO_DATA   = 2'd0;
    localparam logic [1:0] USB_IO_STATUS = 2'd1;
    localparam logic [1:0] USB_IO_CTRL   = 2'd2;

    // STATUS bit positions (bits 7:4 read as zero)
    localparam int unsigned STATUS_RX_NEMPTY = 0;
    localparam int unsigned STATUS_TX_NFULL  = 1;
    localparam int unsigned STATUS_TX_DROP   = 2;
    localparam int unsigned STATUS_TX_EMPTY  = 3;

    // CTRL bit positions; bit 7 is a write-only clear strobe for tx_drop
    localparam int unsigned CTRL_RX_IE       = 0;
    localparam int unsigned CTRL_TX_IE       = 1;
    localparam int unsigned CTRL_TX_DROP_CLR = 7;

endpackage

// File: rtl/usb_io_port_if.sv
// CPU-side register bus of the USB byte I/O peripheral.
//   sel_i   : access targets this block this cycle
//   read_i  : read strobe, qualified by sel_i
//   write_i : write strobe, qualified by sel_i
//   addr_i  : register offset
//   data_i  : write data
//   data_o  : read data, zero unless sel_i & read_i (OR'd onto the CPU bus)
// Signal directions in the names are as seen from the peripheral.
interface usb_io_port_if;
    import usb_io_pkg::*;

    logic       sel_i;
    logic       read_i;
    logic       write_i;
    logic [1:0] addr_i;
    byte_t      data_i;
    byte_t      data_o;

    modport master (
        output sel_i,
        output read_i,
        output write_i,
        output addr_i,
        output data_i,
        input  data_o
    );

    modport slave (
        input  sel_i,
        input  read_i,
        input  write_i,
        input  addr_i,
        input  data_i,
        output data_o
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with 2^DEPTH_LOG2 entries.
//   clk_i, rstn_i : clock, asynchronous active-low reset (flushes pointers)
//   push_i        : write wdata_i; ignored when full (full sampled before the edge)
//   pop_i         : drop the head entry; ignored when empty
//   wdata_i       : data to push
//   rdata_o       : current head, zero when empty (no fall-through of a same-cycle push)
//   empty_o       : no entries
//   full_o        : all entries used
module sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned          Depth  = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  PtrOne = 1;

    // Pointers carry one extra wrap bit to tell full from empty
    logic [DEPTH_LOG2:0] wptr_q, rptr_q;
    logic [WIDTH-1:0]    mem_q [Depth];
    logic                do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                     (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrOne;
            if (do_pop)  rptr_q <= rptr_q + PtrOne;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/usb_io_port.sv
// Memory-mapped byte I/O between the CPU bus and the USB_CDC byte stream.
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   bus           : CPU register bus (DATA/STATUS/CTRL window)
//   rx_irq_o      : registered rx_ie & RX not empty
//   tx_irq_o      : registered tx_ie & TX empty
//   in_data_o     : TX head to USB_CDC (device->host), zero when empty
//   in_valid_o    : TX FIFO not empty
//   in_ready_i    : USB_CDC takes in_data_o this cycle
//   out_data_i    : byte from USB_CDC (host->device)
//   out_valid_i   : out_data_i valid
//   out_ready_o   : RX FIFO not full
module usb_io_port
    import usb_io_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    usb_io_port_if.slave        bus,
    output logic                rx_irq_o,
    output logic                tx_irq_o,
    output byte_t               in_data_o,
    output logic                in_valid_o,
    input  logic                in_ready_i,
    input  byte_t               out_data_i,
    input  logic                out_valid_i,
    output logic                out_ready_o
);

    logic  cpu_rd, cpu_wr;
    logic  rx_push, rx_pop, rx_empty, rx_full;
    logic  tx_push, tx_pop, tx_empty, tx_full;
    byte_t rx_head, tx_head;
    byte_t rdata;

    logic  rx_ie_q, tx_ie_q, tx_drop_q;
    logic  rx_irq_q, tx_irq_q;

    assign cpu_rd = bus.sel_i & bus.read_i;
    assign cpu_wr = bus.sel_i & bus.write_i;

    // RX: host->device, filled by USB, drained by CPU DATA reads
    assign out_ready_o = ~rx_full;
    assign rx_push     = out_valid_i & out_ready_o;
    assign rx_pop      = cpu_rd & (bus.addr_i == USB_IO_DATA);

    sync_fifo #(
        .WIDTH      ($bits(byte_t)),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .wdata_i (out_data_i),
        .rdata_o (rx_head),
        .empty_o (rx_empty),
        .full_o  (rx_full)
    );

    // TX: device->host, filled by CPU DATA writes, drained by USB
    assign in_valid_o = ~tx_empty;
    assign in_data_o  = tx_head;
    assign tx_pop     = in_valid_o & in_ready_i;
    assign tx_push    = cpu_wr & (bus.addr_i == USB_IO_DATA);

    sync_fifo #(
        .WIDTH      ($bits(byte_t)),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .wdata_i (bus.data_i),
        .rdata_o (tx_head),
        .empty_o (tx_empty),
        .full_o  (tx_full)
    );

    // Control bits, sticky drop flag and interrupt flops
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_ie_q   <= 1'b0;
            tx_ie_q   <= 1'b0;
            tx_drop_q <= 1'b0;
            rx_irq_q  <= 1'b0;
            tx_irq_q  <= 1'b0;
        end else begin
            if (cpu_wr && bus.addr_i == USB_IO_CTRL) begin
                rx_ie_q <= bus.data_i[CTRL_RX_IE];
                tx_ie_q <= bus.data_i[CTRL_TX_IE];
                if (bus.data_i[CTRL_TX_DROP_CLR]) tx_drop_q <= 1'b0;
            end
            // Full is judged before the edge; a same-cycle USB pop does not help
            if (tx_push && tx_full) tx_drop_q <= 1'b1;
            rx_irq_q <= rx_ie_q & ~rx_empty;
            tx_irq_q <= tx_ie_q & tx_empty;
        end
    end

    assign rx_irq_o = rx_irq_q;
    assign tx_irq_o = tx_irq_q;

    // Read mux; zero when not read so it can be OR'd onto the CPU bus
    always_comb begin
        rdata = '0;
        if (cpu_rd) begin
            case (bus.addr_i)
                USB_IO_DATA: rdata = rx_head;
                USB_IO_STATUS: begin
                    rdata[STATUS_RX_NEMPTY] = ~rx_empty;
                    rdata[STATUS_TX_NFULL]  = ~tx_full;
                    rdata[STATUS_TX_DROP]   = tx_drop_q;
                    rdata[STATUS_TX_EMPTY]  = tx_empty;
                end
                USB_IO_CTRL: begin
                    rdata[CTRL_RX_IE] = rx_ie_q;
                    rdata[CTRL_TX_IE] = tx_ie_q;
                end
                default: rdata = '0;
            endcase
        end
    end

    assign bus.data_o = rdata;

endmodule

// File: tb/tb_usb_io_port.sv
module tb_usb_io_port;
    import usb_io_pkg::*;

    logic  clk_i = 1'b0;
    logic  rstn_i = 1'b0;
    logic  rx_irq_o, tx_irq_o;
    byte_t in_data_o;
    logic  in_valid_o;
    logic  in_ready_i = 1'b0;
    byte_t out_data_i = '0;
    logic  out_valid_i = 1'b0;
    logic  out_ready_o;

    int    pass_cnt = 0;
    int    total_cnt = 0;

    byte_t rx_q[$];
    byte_t tx_q[$];

    usb_io_port_if bus ();

    usb_io_port #(
        .DEPTH_LOG2 (4)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .bus         (bus),
        .rx_irq_o    (rx_irq_o),
        .tx_irq_o    (tx_irq_o),
        .in_data_o   (in_data_o),
        .in_valid_o  (in_valid_o),
        .in_ready_i  (in_ready_i),
        .out_data_i  (out_data_i),
        .out_valid_i (out_valid_i),
        .out_ready_o (out_ready_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        bus.sel_i   = 1'b0;
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        bus.addr_i  = '0;
        bus.data_i  = '0;
    end

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic bus_read(input logic [1:0] a, output byte_t d);
        @(negedge clk_i);
        bus.sel_i = 1'b1; bus.read_i = 1'b1; bus.write_i = 1'b0; bus.addr_i = a;
        #1 d = bus.data_o;
        @(posedge clk_i);
        #1 bus.sel_i = 1'b0; bus.read_i = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input byte_t d);
        @(negedge clk_i);
        bus.sel_i = 1'b1; bus.write_i = 1'b1; bus.read_i = 1'b0; bus.addr_i = a;
        bus.data_i = d;
        @(posedge clk_i);
        #1 bus.sel_i = 1'b0; bus.write_i = 1'b0;
    endtask

    task automatic usb_push(input byte_t d);
        @(negedge clk_i);
        out_valid_i = 1'b1; out_data_i = d;
        rx_q.push_back(d);
        @(posedge clk_i);
        #1 out_valid_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        byte_t d;
        rstn_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i) rstn_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        total_cnt++;
        if (out_ready_o !== 1'b1) $display("FAIL reset_out_ready got %b want 1", out_ready_o);
        else pass_cnt++;
        total_cnt++;
        if (in_valid_o !== 1'b0) $display("FAIL reset_in_valid got %b want 0", in_valid_o);
        else pass_cnt++;
        total_cnt++;
        if (in_data_o !== 8'h00) $display("FAIL reset_in_data got %h want 00", in_data_o);
        else pass_cnt++;
        total_cnt++;
        if ({rx_irq_o, tx_irq_o} !== 2'b00)
            $display("FAIL reset_irqs got %b want 00", {rx_irq_o, tx_irq_o});
        else pass_cnt++;
        total_cnt++;
        if (bus.data_o !== 8'h00) $display("FAIL reset_data_o_unsel got %h want 00", bus.data_o);
        else pass_cnt++;
        bus_read(USB_IO_STATUS, d);
        total_cnt++;
        if (d !== 8'h0A) $display("FAIL reset_status got %h want 0a", d);
        else pass_cnt++;
    endtask

    task automatic test_rx_basic();
        byte_t d, e;
        usb_push(8'h41);
        usb_push(8'h42);
        for (int i = 0; i < 2; i++) begin
            bus_read(USB_IO_DATA, d);
            e = rx_q.pop_front();
            total_cnt++;
            if (d !== e) $display("FAIL rx_basic_data%0d got %h want %h", i, d, e);
            else pass_cnt++;
        end
        bus_read(USB_IO_STATUS, d);
        total_cnt++;
        if (d !== 8'h0A) $display("FAIL rx_basic_status got %h want 0a", d);
        else pass_cnt++;
        bus_read(USB_IO_DATA, d);
        total_cnt++;
        if (d !== 8'h00) $display("FAIL rx_empty_read got %h want 00", d);
        else pass_cnt++;
    endtask

    task automatic test_rx_irq();
        byte_t d, e;
        bus_write(USB_IO_CTRL, 8'h01);
        usb_push(8'h55);                 // edge t stores the byte
        total_cnt++;
        if (rx_irq_o !== 1'b0) $display("FAIL rx_irq_t1 got %b want 0", rx_irq_o);
        else pass_cnt++;
        @(posedge clk_i); #1;
        total_cnt++;
        if (rx_irq_o !== 1'b1) $display("FAIL rx_irq_t2 got %b want 1", rx_irq_o);
        else pass_cnt++;
        bus_read(USB_IO_DATA, d);
        e = rx_q.pop_front();
        total_cnt++;
        if (d !== e) $display("FAIL rx_irq_data got %h want %h", d, e);
        else pass_cnt++;
        total_cnt++;
        if (rx_irq_o !== 1'b1) $display("FAIL rx_irq_at_pop got %b want 1", rx_irq_o);
        else pass_cnt++;
        @(posedge clk_i); #1;
        total_cnt++;
        if (rx_irq_o !== 1'b0) $display("FAIL rx_irq_after_pop got %b want 0", rx_irq_o);
        else pass_cnt++;
        bus_write(USB_IO_CTRL, 8'h00);
    endtask

    task automatic test_tx_drop();
        byte_t d, e;
        in_ready_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus_write(USB_IO_DATA, 8'(i));
            if (i < 16) tx_q.push_back(8'(i));
        end
        bus_read(USB_IO_STATUS, d);
        total_cnt++;
        if (d !== 8'h04) $display("FAIL tx_full_status got %h want 04", d);
        else pass_cnt++;
        // Head must hold steady while the sink stalls
        repeat (2) @(posedge clk_i);
        #1;
        total_cnt++;
        if (in_valid_o !== 1'b1 || in_data_o !== 8'h00)
            $display("FAIL tx_stall_hold got v=%b d=%h want v=1 d=00", in_valid_o, in_data_o);
        else pass_cnt++;
        @(negedge clk_i);
        in_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            e = tx_q.pop_front();
            total_cnt++;
            if (in_valid_o !== 1'b1 || in_data_o !== e)
                $display("FAIL tx_drain%0d got v=%b d=%h want v=1 d=%h",
                         i, in_valid_o, in_data_o, e);
            else pass_cnt++;
            @(negedge clk_i);
        end
        in_ready_i = 1'b0;
        #1;
        total_cnt++;
        if (in_valid_o !== 1'b0) $display("FAIL tx_drained_valid got %b want 0", in_valid_o);
        else pass_cnt++;
        bus_read(USB_IO_STATUS, d);
        total_cnt++;
        if (d !== 8'h0E) $display("FAIL tx_drop_sticky got %h want 0e", d);
        else pass_cnt++;
        bus_write(USB_IO_CTRL, 8'h80);
        bus_read(USB_IO_STATUS, d);
        total_cnt++;
        if (d !== 8'h0A) $display("FAIL tx_drop_clear got %h want 0a", d);
        else pass_cnt++;
        // TX empty interrupt: one cycle after tx_ie takes effect
        bus_write(USB_IO_CTRL, 8'h02);
        total_cnt++;
        if (tx_irq_o !== 1'b0) $display("FAIL tx_irq_early got %b want 0", tx_irq_o);
        else pass_cnt++;
        @(posedge clk_i); #1;
        total_cnt++;
        if (tx_irq_o !== 1'b1) $display("FAIL tx_irq got %b want 1", tx_irq_o);
        else pass_cnt++;
        bus_read(USB_IO_CTRL, d);
        total_cnt++;
        if (d !== 8'h02) $display("FAIL ctrl_readback got %h want 02", d);
        else pass_cnt++;
        bus_write(USB_IO_CTRL, 8'h00);
        @(posedge clk_i); #1;
        total_cnt++;
        if (tx_irq_o !== 1'b0) $display("FAIL tx_irq_off got %b want 0", tx_irq_o);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        byte_t d, e;
        for (int i = 0; i < 16; i++) usb_push(8'h80 + 8'(i));
        total_cnt++;
        if (out_ready_o !== 1'b0) $display("FAIL rx_full_ready got %b want 0", out_ready_o);
        else pass_cnt++;
        // Pop while USB offers a byte: the push is gated by the pre-edge full flag
        @(negedge clk_i);
        bus.sel_i = 1'b1; bus.read_i = 1'b1; bus.addr_i = USB_IO_DATA;
        out_valid_i = 1'b1; out_data_i = 8'hEE;
        #1 d = bus.data_o;
        e = rx_q.pop_front();
        total_cnt++;
        if (d !== e) $display("FAIL rx_full_pop got %h want %h", d, e);
        else pass_cnt++;
        @(posedge clk_i);
        #1 bus.sel_i = 1'b0; bus.read_i = 1'b0; out_valid_i = 1'b0;
        total_cnt++;
        if (out_ready_o !== 1'b1) $display("FAIL rx_slot_freed got %b want 1", out_ready_o);
        else pass_cnt++;
        usb_push(8'h99);
        total_cnt++;
        if (out_ready_o !== 1'b0) $display("FAIL rx_refull got %b want 0", out_ready_o);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            bus_read(USB_IO_DATA, d);
            e = rx_q.pop_front();
            total_cnt++;
            if (d !== e) $display("FAIL rx_full_drain%0d got %h want %h", i, d, e);
            else pass_cnt++;
        end
        bus_read(USB_IO_STATUS, d);
        total_cnt++;
        if (d !== 8'h0A) $display("FAIL rx_full_end_status got %h want 0a", d);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        byte_t d;
        bus_write(USB_IO_CTRL, 8'h03);
        for (int i = 0; i < 8; i++) usb_push(8'h10 + 8'(i));
        for (int i = 0; i < 8; i++) bus_write(USB_IO_DATA, 8'h20 + 8'(i));
        total_cnt++;
        if (rx_irq_o !== 1'b1 || in_valid_o !== 1'b1 || out_ready_o !== 1'b1)
            $display("FAIL pre_reset got irq=%b v=%b rdy=%b want 1 1 1",
                     rx_irq_o, in_valid_o, out_ready_o);
        else pass_cnt++;
        @(negedge clk_i);
        #2 rstn_i = 1'b0;
        #1;
        total_cnt++;
        if (rx_irq_o !== 1'b0 || tx_irq_o !== 1'b0 || in_valid_o !== 1'b0 ||
            in_data_o !== 8'h00 || out_ready_o !== 1'b1)
            $display("FAIL async_reset got irq=%b%b v=%b d=%h rdy=%b want 00 0 00 1",
                     rx_irq_o, tx_irq_o, in_valid_o, in_data_o, out_ready_o);
        else pass_cnt++;
        rx_q.delete();
        @(negedge clk_i) rstn_i = 1'b1;
        bus_read(USB_IO_STATUS, d);
        total_cnt++;
        if (d !== 8'h0A) $display("FAIL post_reset_status got %h want 0a", d);
        else pass_cnt++;
        bus_read(USB_IO_DATA, d);
        total_cnt++;
        if (d !== 8'h00) $display("FAIL post_reset_data got %h want 00", d);
        else pass_cnt++;
        bus_read(USB_IO_CTRL, d);
        total_cnt++;
        if (d !== 8'h00) $display("FAIL post_reset_ctrl got %h want 00", d);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_rx_irq();
        test_tx_drop();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
